// File: rtl/step_pkg.sv
// Shared constants and types for the step-rate meter and its consumers.
package step_pkg;
    localparam int WINDOW_SEC      = 60;
    localparam int PPM_W           = 10;
    localparam int BIN_W           = 8;
    localparam int HIGH_PPM_THRESH = 64;
    localparam int DEBOUNCE_CYCLES = 16;

    typedef logic [PPM_W-1:0] ppm_t;
    typedef enum logic {FILL = 1'b0, RUN = 1'b1} meter_state_t;
endpackage

// File: rtl/pulse_edge_sync.sv
// Synchronizes the raw step input, optionally debounces it (STEP_RATE_DEBOUNCE_EN),
// and emits a one-cycle registered strobe per rising edge.
module pulse_edge_sync
`ifdef STEP_RATE_DEBOUNCE_EN
    #(parameter int DEBOUNCE_CYCLES = 16)
`endif
(
    input  logic clk,
    input  logic reset,
    input  logic i_pulse,
    output logic o_step
);
    logic r_sync1, r_sync2, r_prev, r_step;
    logic w_level;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_pulse;
            r_sync2 <= r_sync1;
        end
    end

`ifdef STEP_RATE_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    logic             r_deb_lvl;
    logic [CNT_W-1:0] r_deb_cnt;

    // Accept a new level only after it has differed from the held one for DEBOUNCE_CYCLES clk.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_deb_lvl <= 1'b0;
            r_deb_cnt <= '0;
        end else if (r_sync2 == r_deb_lvl) begin
            r_deb_cnt <= '0;
        end else if (r_deb_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            r_deb_lvl <= r_sync2;
            r_deb_cnt <= '0;
        end else begin
            r_deb_cnt <= r_deb_cnt + 1'b1;
        end
    end
    assign w_level = r_deb_lvl;
`else
    assign w_level = r_sync2;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_prev <= 1'b0;
            r_step <= 1'b0;
        end else begin
            r_prev <= w_level;
            r_step <= w_level & ~r_prev;
        end
    end

    assign o_step = r_step;
endmodule

// File: rtl/step_rate_meter.sv
// Step counter with a sliding window of per-second bins, publishing saturated ppm once per tick.
// Optional input debounce is enabled with STEP_RATE_DEBOUNCE_EN.
module step_rate_meter #(
    parameter int WINDOW_SEC = step_pkg::WINDOW_SEC,
    parameter int BIN_W      = step_pkg::BIN_W,
    parameter int PPM_W      = step_pkg::PPM_W
`ifdef STEP_RATE_DEBOUNCE_EN
    , parameter int DEBOUNCE_CYCLES = step_pkg::DEBOUNCE_CYCLES
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pulse_in,
    input  logic             tick_1s,
    output logic [PPM_W-1:0] ppm,
    output logic             ppm_valid,
    output logic             window_full,
    output logic [15:0]      step_total
);
    import step_pkg::*;

    localparam int SUM_W  = $clog2(WINDOW_SEC * (2**BIN_W - 1) + 1);
    localparam int PTR_W  = $clog2(WINDOW_SEC);
    localparam int FILL_W = $clog2(WINDOW_SEC + 1);
    localparam logic [BIN_W-1:0] BIN_MAX = '1;
    localparam logic [SUM_W-1:0] PPM_MAX = SUM_W'(2**PPM_W - 1);

    logic [BIN_W-1:0]  r_bins [WINDOW_SEC];
    logic [BIN_W-1:0]  r_cur;
    logic [SUM_W-1:0]  r_sum;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [FILL_W-1:0] r_fill_cnt;
    meter_state_t      r_state;
    logic [PPM_W-1:0]  r_ppm;
    logic              r_ppm_valid;
    logic              r_window_full;
    logic [15:0]       r_step_total;

    logic              w_step;
    logic [SUM_W-1:0]  w_sum_new;
    logic [PPM_W-1:0]  w_ppm_sat;

    pulse_edge_sync
`ifdef STEP_RATE_DEBOUNCE_EN
        #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES))
`endif
    u_sync (
        .clk     (clk),
        .reset   (reset),
        .i_pulse (pulse_in),
        .o_step  (w_step)
    );

    // The bin being overwritten is always part of r_sum, so this never underflows.
    assign w_sum_new = r_sum + SUM_W'(r_cur) - SUM_W'(r_bins[r_wr_ptr]);
    assign w_ppm_sat = (w_sum_new > PPM_MAX) ? '1 : w_sum_new[PPM_W-1:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < WINDOW_SEC; i++) r_bins[i] <= '0;
            r_cur         <= '0;
            r_sum         <= '0;
            r_wr_ptr      <= '0;
            r_fill_cnt    <= '0;
            r_state       <= FILL;
            r_ppm         <= '0;
            r_ppm_valid   <= 1'b0;
            r_window_full <= 1'b0;
            r_step_total  <= '0;
        end else begin
            r_ppm_valid <= tick_1s;
            if (w_step) r_step_total <= r_step_total + 1'b1;

            if (tick_1s) begin
                r_bins[r_wr_ptr] <= r_cur;
                r_sum            <= w_sum_new;
                r_ppm            <= w_ppm_sat;
                r_wr_ptr         <= (r_wr_ptr == PTR_W'(WINDOW_SEC - 1)) ? '0 : r_wr_ptr + 1'b1;
                // A step landing on the tick opens the new second.
                r_cur            <= BIN_W'(w_step);
                case (r_state)
                    FILL: begin
                        if (r_fill_cnt == FILL_W'(WINDOW_SEC - 1)) begin
                            r_state       <= RUN;
                            r_window_full <= 1'b1;
                        end
                        r_fill_cnt <= r_fill_cnt + 1'b1;
                    end
                    RUN: ;
                    default: r_state <= FILL;
                endcase
            end else if (w_step && r_cur != BIN_MAX) begin
                r_cur <= r_cur + 1'b1;
            end
        end
    end

    assign ppm         = r_ppm;
    assign ppm_valid   = r_ppm_valid;
    assign window_full = r_window_full;
    assign step_total  = r_step_total;
endmodule

// File: tb/tb_step_rate_meter.sv
// Self-checking bench for step_rate_meter: phase table, hand-written corner cases, random seconds.
module tb_step_rate_meter;
`ifdef STEP_RATE_DEBOUNCE_EN
    localparam int HOLD  = 18;
    localparam int DRAIN = 24;
    localparam int LAT   = 19;
    localparam int RMAX  = 4;
`else
    localparam int HOLD  = 2;
    localparam int DRAIN = 5;
    localparam int LAT   = 3;
    localparam int RMAX  = 12;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       pulse_in = 1'b0;
    logic       tick_1s = 1'b0;
    logic [9:0] ppm;
    logic       ppm_valid;
    logic       window_full;
    logic [15:0] step_total;

    step_rate_meter dut (
        .clk         (clk),
        .reset       (reset),
        .pulse_in    (pulse_in),
        .tick_1s     (tick_1s),
        .ppm         (ppm),
        .ppm_valid   (ppm_valid),
        .window_full (window_full),
        .step_total  (step_total)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    // Reference model: list of closed seconds, current count, totals.
    int m_bins[$];
    int m_cur, m_total, m_ticks;

    typedef struct {
        int spp;
        int n_ticks;
        int exp_ppm;
        int exp_full;
    } phase_t;
    phase_t tbl[5];

    function automatic int model_ppm();
        int s = 0;
        foreach (m_bins[i]) s += m_bins[i];
        return (s > 1023) ? 1023 : s;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0; pulse_in = 1'b0; tick_1s = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        m_bins.delete(); m_cur = 0; m_total = 0; m_ticks = 0;
    endtask

    task automatic pulses(input int n);
        for (int k = 0; k < n; k++) begin
            pulse_in = 1'b1;
            repeat (HOLD) @(negedge clk);
            pulse_in = 1'b0;
            repeat (HOLD) @(negedge clk);
        end
        m_cur += n;
        m_total += n;
    endtask

    task automatic close_second_model();
        m_bins.push_back((m_cur > 255) ? 255 : m_cur);
        if (m_bins.size() > 60) void'(m_bins.pop_front());
        m_ticks++;
        m_cur = 0;
    endtask

    task automatic tick_check(input string name);
        repeat (DRAIN) @(negedge clk);
        tick_1s = 1'b1;
        @(negedge clk);
        tick_1s = 1'b0;
        close_second_model();
        chk({name, "_ppm"}, ppm, model_ppm());
        chk({name, "_valid"}, ppm_valid, 1);
        chk({name, "_full"}, window_full, (m_ticks >= 60) ? 1 : 0);
        chk({name, "_total"}, step_total, m_total % 65536);
        @(negedge clk);
        chk({name, "_valid_drop"}, ppm_valid, 0);
    endtask

    initial begin
        tbl[0] = '{2, 60, 120, 1};
        tbl[1] = '{2, 1, 120, 1};
        tbl[2] = '{0, 59, 2, 1};
        tbl[3] = '{0, 1, 0, 1};
        tbl[4] = '{20, 60, 1023, 1};

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_ppm", ppm, 0);
        chk("rst_valid", ppm_valid, 0);
        chk("rst_full", window_full, 0);
        chk("rst_total", step_total, 0);
        reset = 1'b1;
        m_bins.delete(); m_cur = 0; m_total = 0; m_ticks = 0;

        // Five steps then one tick
        @(negedge clk);
        pulses(5);
        tick_check("five");
        chk("five_const_ppm", ppm, 5);
        chk("five_const_total", step_total, 5);

        // Phase table: fill, steady, drain with pointer wrap, saturation
        do_reset();
        for (int p = 0; p < 5; p++) begin
            for (int t = 0; t < tbl[p].n_ticks; t++) begin
                pulses(tbl[p].spp);
                tick_check($sformatf("ph%0d_t%0d", p, t));
            end
            chk($sformatf("ph%0d_end_ppm", p), ppm, tbl[p].exp_ppm);
            chk($sformatf("ph%0d_end_full", p), window_full, tbl[p].exp_full);
        end

        // Bin saturation
        do_reset();
        pulses(300);
        tick_check("bin_sat");
        chk("bin_sat_ppm", ppm, 255);
        chk("bin_sat_total", step_total, 300);

        // Step coincident with tick
        do_reset();
        pulses(2);
        repeat (DRAIN) @(negedge clk);
        pulse_in = 1'b1;
        repeat (LAT) @(negedge clk);
        tick_1s = 1'b1;
        @(negedge clk);
        tick_1s = 1'b0;
        chk("coinc_ppm", ppm, 2);
        chk("coinc_total", step_total, 3);
        repeat (HOLD) @(negedge clk);
        pulse_in = 1'b0;
        repeat (HOLD) @(negedge clk);
        m_bins.push_back(2); m_ticks = 1; m_cur = 1; m_total = 3;
        tick_check("coinc_next");
        chk("coinc_next_ppm", ppm, 3);

        // Asynchronous reset mid-window
        do_reset();
        pulses(20);
        tick_check("mid_a");
        pulses(20);
        tick_check("mid_b");
        chk("mid_ppm40", ppm, 40);
        pulses(4);
        #2 reset = 1'b0;
        #1;
        chk("async_ppm", ppm, 0);
        chk("async_valid", ppm_valid, 0);
        chk("async_full", window_full, 0);
        chk("async_total", step_total, 0);
        @(negedge clk);
        reset = 1'b1;
        m_bins.delete(); m_cur = 0; m_total = 0; m_ticks = 0;
        pulses(3);
        tick_check("post_rst");
        chk("post_rst_ppm", ppm, 3);

`ifdef STEP_RATE_DEBOUNCE_EN
        // Short glitch is filtered
        do_reset();
        pulse_in = 1'b1;
        repeat (5) @(negedge clk);
        pulse_in = 1'b0;
        repeat (40) @(negedge clk);
        chk("glitch_total", step_total, 0);
        pulses(1);
        repeat (DRAIN) @(negedge clk);
        chk("deb_step_total", step_total, 1);
`endif

        // Random seconds against the model, past the window wrap
        do_reset();
        for (int s = 0; s < 70; s++) begin
            pulses($urandom_range(0, RMAX));
            tick_check($sformatf("rnd%0d", s));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
